io_mailbox: RTL and testbench

IO_MAILBOX -- requirements
Module: io_mailbox

---
 rtl/io_mailbox.sv | 247 ++++++++++++++++++++++++
 tb/tb_io_mailbox.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_mailbox.sv
// -----------------------------------------------------------------------------
// io_mailbox
//
// Memory-mapped mailbox between a 16-bit core bus and two streaming ports.
// The core sees a 4-word register window starting at BASE_ADDR:
//
//   offset 0  TXDATA  write: push into TX FIFO (dropped and flagged when full)
//                     read : 16'h0000
//   offset 1  RXDATA  read : RX head word, popped; 16'h0000 when empty
//                     write: ignored
//   offset 2  STATUS  read : {3'b0, tx_drop, rx_count[3:0], tx_count[3:0],
//                             rx_empty, rx_full, tx_empty, tx_full}
//                     write: data bit 12 = 1 clears tx_drop
//   offset 3  TIMER   free-running up-counter; write loads it
//
// Ports
//   clk          single clock, all state changes on the rising edge
//   reset        asynchronous, active-low; clears every piece of state
//   address_bus  core address
//   data_bus     shared core data bus; driven only for a read hit
//   mem_read     core read strobe
//   mem_write    core write strobe (both strobes high = no access)
//   tx_data      TX FIFO head word
//   tx_valid     TX FIFO non-empty
//   tx_ready     external sink accepts tx_data this cycle
//   rx_data      external word for the RX FIFO
//   rx_valid     rx_data is valid
//   rx_ready     RX FIFO not full
//   irq          registered (rx_count != 0)
//
// Handshakes
//   TX: a word transfers on every rising edge where tx_valid and tx_ready are
//   both high; tx_data then shows the next entry in the following cycle.
//   RX: a word transfers on every rising edge where rx_valid and rx_ready are
//   both high. rx_ready is a pure function of the RX count (not full). A full
//   RX FIFO additionally takes rx_data in a cycle where the core pops the
//   head, because that pop frees the slot the new word lands in; the count
//   then stays at DEPTH and rx_ready stays low.
// -----------------------------------------------------------------------------
module io_mailbox #(
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter int          DEPTH     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address_bus,
    inout  wire  [15:0] data_bus,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        OFF_TXDATA = 2'd0,
        OFF_RXDATA = 2'd1,
        OFF_STATUS = 2'd2,
        OFF_TIMER  = 2'd3
    } reg_offset_t;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    // 17-bit difference so a window near the top of the address space
    // cannot alias onto low addresses: an address below BASE_ADDR sets
    // bit 16, one beyond the window sets some bit in 15:2.
    logic [16:0] addr_diff;
    logic        hit;
    reg_offset_t offset;
    logic        rd_access;
    logic        wr_access;

    assign addr_diff = {1'b0, address_bus} - {1'b0, BASE_ADDR};
    assign hit       = (addr_diff[16:2] == 15'd0);
    assign offset    = reg_offset_t'(addr_diff[1:0]);

    // Gating with reset keeps accesses inert while reset is held.
    assign rd_access = hit && mem_read && !mem_write && reset;
    assign wr_access = hit && mem_write && !mem_read && reset;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [15:0]   tx_mem [DEPTH];
    logic [AW-1:0] tx_wr_ptr;
    logic [AW-1:0] tx_rd_ptr;
    logic [CW-1:0] tx_count;
    logic          tx_full;
    logic          tx_empty;
    logic          tx_push_req;
    logic          tx_push;
    logic          tx_pop;
    logic          tx_drop_set;

    assign tx_full     = (tx_count == FULL_COUNT);
    assign tx_empty    = (tx_count == '0);
    assign tx_valid    = !tx_empty && reset;
    assign tx_data     = tx_mem[tx_rd_ptr];
    assign tx_pop      = tx_valid && tx_ready;
    assign tx_push_req = wr_access && (offset == OFF_TXDATA);
    // Fullness is judged at cycle start: a same-cycle external pop does
    // not rescue a write that arrives while the FIFO is full.
    assign tx_push     = tx_push_req && !tx_full;
    assign tx_drop_set = tx_push_req && tx_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tx_mem[i] <= '0;
            end
        end else begin
            if (tx_push) begin
                tx_mem[tx_wr_ptr] <= data_bus;
                tx_wr_ptr         <= tx_wr_ptr + 1'b1;
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [15:0]   rx_mem [DEPTH];
    logic [AW-1:0] rx_wr_ptr;
    logic [AW-1:0] rx_rd_ptr;
    logic [CW-1:0] rx_count;
    logic          rx_full;
    logic          rx_empty;
    logic          rx_push;
    logic          rx_pop;

    assign rx_full  = (rx_count == FULL_COUNT);
    assign rx_empty = (rx_count == '0);
    assign rx_ready = !rx_full && reset;
    assign rx_pop   = rd_access && (offset == OFF_RXDATA) && !rx_empty;
    // Full FIFO still accepts a word when the core frees the head slot in
    // the same cycle.
    assign rx_push  = rx_valid && reset && (!rx_full || rx_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rx_mem[i] <= '0;
            end
        end else begin
            if (rx_push) begin
                rx_mem[rx_wr_ptr] <= rx_data;
                rx_wr_ptr         <= rx_wr_ptr + 1'b1;
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + 1'b1;
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky TX drop flag, timer and interrupt
    // ------------------------------------------------------------------
    logic        tx_drop;
    logic [15:0] timer;
    logic        status_clear;
    logic        timer_load;

    assign status_clear = wr_access && (offset == OFF_STATUS) && data_bus[12];
    assign timer_load   = wr_access && (offset == OFF_TIMER);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_drop <= 1'b0;
        end else if (tx_drop_set) begin
            // A new drop outranks a clear arriving in the same cycle.
            tx_drop <= 1'b1;
        end else if (status_clear) begin
            tx_drop <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (timer_load) begin
            timer <= data_bus;
        end else begin
            timer <= timer + 16'd1;
        end
    end

    // irq follows the count registered at the previous edge, so it rises
    // and falls one cycle after rx_count changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq <= 1'b0;
        end else begin
            irq <= !rx_empty;
        end
    end

    // ------------------------------------------------------------------
    // Read path: combinational, valid within the strobe cycle
    // ------------------------------------------------------------------
    logic [15:0] status_word;
    logic [15:0] rd_data;

    assign status_word = {3'b000, tx_drop, 4'(rx_count), 4'(tx_count),
                          rx_empty, rx_full, tx_empty, tx_full};

    always_comb begin
        rd_data = '0;
        case (offset)
            OFF_TXDATA: rd_data = '0;
            OFF_RXDATA: rd_data = rx_empty ? 16'h0000 : rx_mem[rx_rd_ptr];
            OFF_STATUS: rd_data = status_word;
            OFF_TIMER:  rd_data = timer;
            default:    rd_data = '0;
        endcase
    end

    assign data_bus = rd_access ? rd_data : 16'hzzzz;

endmodule

// File: tb/tb_io_mailbox.sv
// Bench for io_mailbox: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based model.
module tb_io_mailbox;
  localparam logic [15:0] BASE = 16'hFF00;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [15:0] address_bus;
  tri1  [15:0] data_bus;     // floats to 16'hFFFF when nobody drives it
  logic        mem_read;
  logic        mem_write;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        irq;

  logic        db_en;
  logic [15:0] db_drv;
  assign data_bus = db_en ? db_drv : 16'hzzzz;

  io_mailbox #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .address_bus(address_bus),
    .data_bus(data_bus),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .irq(irq)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int failures = 0;

  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  logic        drop_m;
  logic        irq_m;
  logic [15:0] timer_m;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_window(input logic [15:0] addr);
    return (int'(addr) >= int'(BASE)) && (int'(addr) <= int'(BASE) + 3);
  endfunction

  function automatic logic [15:0] model_read(input int off);
    logic [15:0] s;
    s = 16'h0000;
    case (off)
      1: s = (rx_q.size() > 0) ? rx_q[0] : 16'h0000;
      2: begin
        s[0]     = (tx_q.size() == DEPTH);
        s[1]     = (tx_q.size() == 0);
        s[2]     = (rx_q.size() == DEPTH);
        s[3]     = (rx_q.size() == 0);
        s[7:4]   = 4'(tx_q.size());
        s[11:8]  = 4'(rx_q.size());
        s[12]    = drop_m;
      end
      3: s = timer_m;
      default: s = 16'h0000;
    endcase
    return s;
  endfunction

  task automatic model_clear();
    tx_q.delete();
    rx_q.delete();
    drop_m  = 1'b0;
    irq_m   = 1'b0;
    timer_m = 16'h0000;
  endtask

  // Applies one rising edge worth of behaviour from the current inputs.
  task automatic model_edge();
    int  tsz;
    int  rsz;
    int  off;
    bit  rd;
    bit  wr;
    bit  rpop;
    if (!reset) return;
    tsz  = tx_q.size();
    rsz  = rx_q.size();
    off  = int'(address_bus) - int'(BASE);
    rd   = mem_read && !mem_write && in_window(address_bus);
    wr   = mem_write && !mem_read && in_window(address_bus);
    irq_m = (rsz != 0);
    if (tsz > 0 && tx_ready) void'(tx_q.pop_front());
    if (wr && off == 0) begin
      if (tsz == DEPTH) drop_m = 1'b1;
      else tx_q.push_back(db_drv);
    end
    if (wr && off == 2 && db_drv[12]) drop_m = 1'b0;
    rpop = rd && off == 1 && rsz > 0;
    if (rpop) void'(rx_q.pop_front());
    if (rx_valid && (rsz < DEPTH || rpop)) rx_q.push_back(rx_data);
    timer_m = (wr && off == 3) ? db_drv : timer_m + 16'd1;
  endtask

  task automatic check_outputs();
    if (!reset) begin
      chk("rst_tx_valid", {15'b0, tx_valid}, 16'h0000);
      chk("rst_rx_ready", {15'b0, rx_ready}, 16'h0000);
      chk("rst_irq", {15'b0, irq}, 16'h0000);
      if (!db_en) chk("rst_bus_z", data_bus, 16'hFFFF);
    end else begin
      chk("tx_valid", {15'b0, tx_valid}, {15'b0, tx_q.size() > 0});
      if (tx_q.size() > 0) chk("tx_data", tx_data, tx_q[0]);
      chk("rx_ready", {15'b0, rx_ready}, {15'b0, rx_q.size() < DEPTH});
      chk("irq", {15'b0, irq}, {15'b0, irq_m});
      if (!db_en) begin
        if (mem_read && !mem_write && in_window(address_bus))
          chk("read_data", data_bus, model_read(int'(address_bus) - int'(BASE)));
        else
          chk("bus_released", data_bus, 16'hFFFF);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change at the falling edge; outputs are compared shortly after,
  // and the model steps at the rising edge together with the DUT.
  task automatic cyc();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] d);
    mem_read    = rd;
    mem_write   = wr;
    address_bus = addr;
    db_drv      = d;
    db_en       = wr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic random_cycles(input int n);
    bit fill;
    int op;
    logic [15:0] addr;
    for (int i = 0; i < n; i++) begin
      fill = ((i / 200) % 2) == 0;
      tx_ready = fill ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) != 0);
      rx_valid = fill ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) == 0);
      rx_data  = 16'($urandom);
      if ($urandom_range(0, 19) == 0) addr = 16'($urandom);
      else addr = 16'(int'(BASE) + int'($urandom_range(0, 5)) - 1);
      op = $urandom_range(0, 9);
      if (op < 4)       drive(1'b1, 1'b0, addr, 16'h0000);
      else if (op < 8)  drive(1'b0, 1'b1, addr, 16'($urandom));
      else if (op == 8) drive(1'b1, 1'b1, addr, 16'($urandom));
      else              idle();
      cyc();
    end
    idle();
    tx_ready = 1'b0;
    rx_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b0;
    idle();
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 16'h0000;
    model_clear();
    @(negedge clk);
    cyc();
    cyc();
    reset = 1'b1;
    drive(1'b1, 1'b0, BASE + 16'd2, 16'h0000);
    #1 chk("reset_status", data_bus, 16'h000A);
    drive(1'b1, 1'b0, BASE + 16'd3, 16'h0000);
    #1 chk("reset_timer", data_bus, 16'h0000);
    idle();
    cyc();

    // Two TX words held, then streamed out.
    drive(1'b0, 1'b1, BASE, 16'h1234); cyc();
    drive(1'b0, 1'b1, BASE, 16'hABCD); cyc();
    drive(1'b1, 1'b0, BASE + 16'd2, 16'h0000);
    #1;
    chk("tx_valid_held", {15'b0, tx_valid}, 16'h0001);
    chk("tx_head_1234", tx_data, 16'h1234);
    chk("status_txcnt2", {12'b0, data_bus[7:4]}, 16'h0002);
    cyc();
    idle();
    tx_ready = 1'b1;
    #1 chk("tx_out_first", tx_data, 16'h1234);
    cyc();
    #1 chk("tx_out_second", tx_data, 16'hABCD);
    cyc();
    tx_ready = 1'b0;
    #1 chk("tx_drained", {15'b0, tx_valid}, 16'h0000);
    cyc();

    // TX overflow and drop flag clear.
    for (int i = 0; i <= DEPTH; i++) begin
      drive(1'b0, 1'b1, BASE, 16'(16'h2000 + i));
      cyc();
    end
    drive(1'b1, 1'b0, BASE + 16'd2, 16'h0000);
    #1 chk("status_full_drop", data_bus, 16'h1089);
    cyc();
    drive(1'b0, 1'b1, BASE + 16'd2, 16'h1000); cyc();
    drive(1'b1, 1'b0, BASE + 16'd2, 16'h0000);
    #1 chk("status_drop_cleared", data_bus, 16'h0089);
    cyc();
    idle();
    tx_ready = 1'b1;
    repeat (DEPTH) cyc();
    tx_ready = 1'b0;
    cyc();

    // Single RX word, irq timing, read-pop and empty read.
    rx_valid = 1'b1;
    rx_data  = 16'h0055;
    cyc();
    rx_valid = 1'b0;
    #1 chk("irq_not_yet", {15'b0, irq}, 16'h0000);
    cyc();
    #1 chk("irq_set", {15'b0, irq}, 16'h0001);
    drive(1'b1, 1'b0, BASE + 16'd1, 16'h0000);
    #1 chk("rx_read_0055", data_bus, 16'h0055);
    cyc();
    drive(1'b1, 1'b0, BASE + 16'd2, 16'h0000);
    #1 chk("status_rx_empty", data_bus, 16'h000A);
    cyc();
    drive(1'b1, 1'b0, BASE + 16'd1, 16'h0000);
    #1;
    chk("irq_cleared", {15'b0, irq}, 16'h0000);
    chk("rx_read_empty", data_bus, 16'h0000);
    cyc();
    idle();

    // RX full, pop and push in one cycle.
    rx_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rx_data = 16'(16'h3000 + i);
      cyc();
    end
    rx_data = 16'h3FFF;
    drive(1'b1, 1'b0, BASE + 16'd1, 16'h0000);
    #1;
    chk("rx_ready_full", {15'b0, rx_ready}, 16'h0000);
    chk("rx_read_head_full", data_bus, 16'h3000);
    cyc();
    rx_valid = 1'b0;
    drive(1'b1, 1'b0, BASE + 16'd2, 16'h0000);
    #1;
    chk("status_rx_still_full", data_bus, 16'h0806);
    chk("rx_ready_still_low", {15'b0, rx_ready}, 16'h0000);
    cyc();
    drive(1'b1, 1'b0, BASE + 16'd1, 16'h0000);
    repeat (DEPTH) cyc();
    idle();
    cyc();

    // Timer load and wrap.
    drive(1'b0, 1'b1, BASE + 16'd3, 16'hFFFE); cyc();
    drive(1'b1, 1'b0, BASE + 16'd3, 16'h0000);
    #1 chk("timer_fffe", data_bus, 16'hFFFE);
    cyc();
    #1 chk("timer_ffff", data_bus, 16'hFFFF);
    cyc();
    #1 chk("timer_wrap", data_bus, 16'h0000);
    cyc();
    idle();

    random_cycles(1600);

    // Reset mid-transfer with TX words queued.
    drive(1'b0, 1'b1, BASE, 16'h0A01); cyc();
    drive(1'b0, 1'b1, BASE, 16'h0A02); cyc();
    drive(1'b0, 1'b1, BASE, 16'h0A03); cyc();
    idle();
    tx_ready = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 16'h0BBB;
    #1 reset = 1'b0;
    model_clear();
    #1;
    chk("mid_rst_tx_valid", {15'b0, tx_valid}, 16'h0000);
    chk("mid_rst_rx_ready", {15'b0, rx_ready}, 16'h0000);
    drive(1'b1, 1'b0, BASE + 16'd2, 16'h0000);
    #1 chk("mid_rst_bus_z", data_bus, 16'hFFFF);
    @(negedge clk);
    cyc();
    cyc();
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    reset = 1'b1;
    drive(1'b1, 1'b0, BASE + 16'd2, 16'h0000);
    #1 chk("post_rst_status", data_bus, 16'h000A);
    drive(1'b1, 1'b0, BASE + 16'd3, 16'h0000);
    #1 chk("post_rst_timer", data_bus, 16'h0000);
    drive(1'b1, 1'b0, 16'h1234, 16'h0000);
    #1 chk("outside_window_z", data_bus, 16'hFFFF);
    cyc();
    idle();

    random_cycles(1600);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
